// File: rtl/dmem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl_if
// Description : Request/response bus between the load/store unit and dmem_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_ctrl_if #(
  parameter int WIDTH_ADDR_LENGTH = 32,
  parameter int WIDTH_DATA_LENGTH = 32
);
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_we;
  logic [1:0]                   req_size;
  logic                         req_unsigned;
  logic [WIDTH_ADDR_LENGTH-1:0] req_addr;
  logic [WIDTH_DATA_LENGTH-1:0] req_wdata;
  logic                         rsp_valid;
  logic [WIDTH_DATA_LENGTH-1:0] rsp_rdata;
  logic                         rsp_fault;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Byte-addressed little-endian data memory with optional wait
//               states, sub-word sign/zero extension and fault detection.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
  parameter int WIDTH_ADDR_LENGTH = 32,
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int MEM_DEPTH         = 1024,
  parameter int WAIT_STATES       = 0
) (
  input  wire logic   clk,
  input  wire logic   rst,
  dmem_ctrl_if.slave  bus
);

  localparam int c_IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                       r_state;
  logic [3:0]                   r_cnt;
  logic                         r_req_ready;
  logic                         r_rsp_valid;
  logic [WIDTH_DATA_LENGTH-1:0] r_rsp_rdata;
  logic                         r_rsp_fault;

  logic                         r_we;
  logic [1:0]                   r_size;
  logic                         r_uns;
  logic [WIDTH_ADDR_LENGTH-1:0] r_addr;
  logic [WIDTH_DATA_LENGTH-1:0] r_wdata;

  logic [7:0] r_mem [MEM_DEPTH];

  logic                         w_in_idle;
  logic                         w_access;
  logic                         w_we;
  logic [1:0]                   w_size;
  logic                         w_uns;
  logic [WIDTH_ADDR_LENGTH-1:0] w_addr;
  logic [WIDTH_DATA_LENGTH-1:0] w_wdata;
  logic                         w_oor;
  logic                         w_fault;
  logic [c_IDX_W-1:0]           w_idx0;
  logic [c_IDX_W-1:0]           w_idx1;
  logic [c_IDX_W-1:0]           w_idx2;
  logic [c_IDX_W-1:0]           w_idx3;
  logic [7:0]                   w_b0;
  logic [7:0]                   w_b1;
  logic [7:0]                   w_b2;
  logic [7:0]                   w_b3;
  logic [WIDTH_DATA_LENGTH-1:0] w_load;

  // With zero wait states the access happens on the accepting edge, so the
  // live request fields are used; otherwise the captured copy is used.
  assign w_in_idle = (r_state == S_IDLE);
  assign w_access  = (w_in_idle && bus.req_valid && (WAIT_STATES == 0)) ||
                     ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_we      = w_in_idle ? bus.req_we       : r_we;
  assign w_size    = w_in_idle ? bus.req_size     : r_size;
  assign w_uns     = w_in_idle ? bus.req_unsigned : r_uns;
  assign w_addr    = w_in_idle ? bus.req_addr     : r_addr;
  assign w_wdata   = w_in_idle ? bus.req_wdata    : r_wdata;

  generate
    if (c_IDX_W < WIDTH_ADDR_LENGTH) begin : g_range_check
      assign w_oor = |w_addr[WIDTH_ADDR_LENGTH-1:c_IDX_W];
    end else begin : g_no_range_check
      assign w_oor = 1'b0;
    end
  endgenerate

  assign w_fault = (w_size == 2'b10) ||
                   ((w_size == 2'b01) && w_addr[0]) ||
                   ((w_size == 2'b11) && (w_addr[1:0] != 2'b00)) ||
                   w_oor;

  assign w_idx0 = w_addr[c_IDX_W-1:0];
  assign w_idx1 = w_idx0 + c_IDX_W'(1);
  assign w_idx2 = w_idx0 + c_IDX_W'(2);
  assign w_idx3 = w_idx0 + c_IDX_W'(3);
  assign w_b0   = r_mem[w_idx0];
  assign w_b1   = r_mem[w_idx1];
  assign w_b2   = r_mem[w_idx2];
  assign w_b3   = r_mem[w_idx3];

  always_comb begin
    w_load = '0;
    case (w_size)
      2'b00:   w_load = w_uns ? {24'd0, w_b0} : {{24{w_b0[7]}}, w_b0};
      2'b01:   w_load = w_uns ? {16'd0, w_b1, w_b0} : {{16{w_b1[7]}}, w_b1, w_b0};
      2'b11:   w_load = {w_b3, w_b2, w_b1, w_b0};
      default: w_load = '0;
    endcase
  end

  // Array is deliberately not reset; reset still blocks a pending write.
  always_ff @(posedge clk) begin
    if (!rst && w_access && w_we && !w_fault) begin
      r_mem[w_idx0] <= w_wdata[7:0];
      if (w_size != 2'b00) begin
        r_mem[w_idx1] <= w_wdata[15:8];
      end
      if (w_size == 2'b11) begin
        r_mem[w_idx2] <= w_wdata[23:16];
        r_mem[w_idx3] <= w_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_size      <= bus.req_size;
            r_uns       <= bus.req_unsigned;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_fault <= w_fault;
              r_rsp_rdata <= (w_fault || w_we) ? '0 : w_load;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= w_fault;
            r_rsp_rdata <= (w_fault || w_we) ? '0 : w_load;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_fault = r_rsp_fault;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Randomized self-checking bench for dmem_ctrl, zero and three
//               wait-state instances against a byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rv   [2];
  logic        rwe  [2];
  logic [1:0]  rsz  [2];
  logic        runs [2];
  logic [31:0] radr [2];
  logic [31:0] rwd  [2];
  logic        rdy  [2];
  logic        vld  [2];
  logic [31:0] rdt  [2];
  logic        flt  [2];

  dmem_ctrl_if #(.WIDTH_ADDR_LENGTH(32), .WIDTH_DATA_LENGTH(32)) bus0 ();
  dmem_ctrl_if #(.WIDTH_ADDR_LENGTH(32), .WIDTH_DATA_LENGTH(32)) bus1 ();

  assign bus0.req_valid    = rv[0];
  assign bus0.req_we       = rwe[0];
  assign bus0.req_size     = rsz[0];
  assign bus0.req_unsigned = runs[0];
  assign bus0.req_addr     = radr[0];
  assign bus0.req_wdata    = rwd[0];
  assign rdy[0] = bus0.req_ready;
  assign vld[0] = bus0.rsp_valid;
  assign rdt[0] = bus0.rsp_rdata;
  assign flt[0] = bus0.rsp_fault;

  assign bus1.req_valid    = rv[1];
  assign bus1.req_we       = rwe[1];
  assign bus1.req_size     = rsz[1];
  assign bus1.req_unsigned = runs[1];
  assign bus1.req_addr     = radr[1];
  assign bus1.req_wdata    = rwd[1];
  assign rdy[1] = bus1.req_ready;
  assign vld[1] = bus1.rsp_valid;
  assign rdt[1] = bus1.rsp_rdata;
  assign flt[1] = bus1.rsp_fault;

  dmem_ctrl #(.WIDTH_ADDR_LENGTH(32), .WIDTH_DATA_LENGTH(32),
              .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  dmem_ctrl #(.WIDTH_ADDR_LENGTH(32), .WIDTH_DATA_LENGTH(32),
              .MEM_DEPTH(1024), .WAIT_STATES(3)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  logic [7:0] mdl [2][1024];
  int n_checks = 0;
  int n_errors = 0;

  function automatic int ws_of(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: fault rules, then little-endian byte gather/scatter.
  function automatic void model(input int d, input logic we, input logic [1:0] sz,
                                input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] er, output logic ef);
    int     n;
    longint v;
    ef = (sz == 2'b10) || (sz == 2'b01 && (a % 2) != 0) ||
         (sz == 2'b11 && (a % 4) != 0) || (a >= 32'd1024);
    er = 32'd0;
    if (ef) return;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (we) begin
      for (int i = 0; i < n; i++) mdl[d][int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(mdl[d][int'(a) + i]) << (8*i));
      if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
      er = v[31:0];
    end
  endfunction

  task automatic do_req(input int d, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic f);
    logic [31:0] er;
    logic        ef;
    int          lat;
    bit          got;
    check("ready_idle", 32'(rdy[d]), 32'd1);
    rv[d] = 1'b1; rwe[d] = we; rsz[d] = sz; runs[d] = uns; radr[d] = a; rwd[d] = wd;
    @(posedge clk);
    #1;
    rv[d] = 1'b0; rwe[d] = 1'($urandom); rsz[d] = 2'($urandom); runs[d] = 1'($urandom);
    radr[d] = $urandom; rwd[d] = $urandom;
    model(d, we, sz, uns, a, wd, er, ef);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (vld[d]) got = 1'b1;
      else check("ready_busy", 32'(rdy[d]), 32'd0);
    end
    rd = 32'd0;
    f  = 1'b0;
    if (!got) begin
      check("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    rd = rdt[d];
    f  = flt[d];
    check("latency", 32'(lat), 32'(1 + ws_of(d)));
    check("ready_resp", 32'(rdy[d]), 32'd0);
    check("fault", 32'(f), 32'(ef));
    check("rdata", rd, er);
    @(negedge clk);
    check("pulse_len", 32'(vld[d]), 32'd0);
    check("ready_back", 32'(rdy[d]), 32'd1);
    check("hold_rdata", rdt[d], rd);
    check("hold_fault", 32'(flt[d]), 32'(f));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, old;
    logic        f;
    int          seen;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rwe[d] = 1'b0; rsz[d] = 2'b00; runs[d] = 1'b0; radr[d] = '0; rwd[d] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(rdy[d]), 32'd1);
      check("rst_valid", 32'(vld[d]), 32'd0);
      check("rst_rdata", rdt[d], 32'd0);
      check("rst_fault", 32'(flt[d]), 32'd0);
    end

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 256; w++) do_req(d, 1'b1, 2'b11, 1'b0, 32'(w * 4), $urandom, rd, f);

    do_req(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, rd, f);
    check("st_word_fault", 32'(f), 32'd0);
    do_req(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, f);
    check("ld_word", rd, 32'hDEADBEEF);
    do_req(0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, f);
    check("ld_byte_s", rd, 32'hFFFFFFEF);
    do_req(0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, rd, f);
    check("ld_byte_u", rd, 32'h000000EF);
    do_req(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, f);
    check("ld_half_s", rd, 32'hFFFFDEAD);
    do_req(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, f);
    check("ld_half_u", rd, 32'h0000DEAD);
    do_req(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hAABBCC55, rd, f);
    do_req(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, f);
    check("byte_lane", rd, 32'hDEAD55EF);

    do_req(0, 1'b1, 2'b11, 1'b0, 32'h0, 32'h12345678, rd, f);
    do_req(0, 1'b1, 2'b11, 1'b0, 32'h2, 32'hFFFFFFFF, rd, f);
    check("mis_st_fault", 32'(f), 32'd1);
    check("mis_st_rdata", rd, 32'd0);
    do_req(0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, rd, f);
    check("mis_st_nowrite", rd, 32'h12345678);
    do_req(0, 1'b0, 2'b01, 1'b0, 32'h3, 32'h0, rd, f);
    check("mis_half_fault", 32'(f), 32'd1);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, f);
    check("size10_fault", 32'(f), 32'd1);
    do_req(0, 1'b0, 2'b11, 1'b0, 32'h400, 32'h0, rd, f);
    check("range_fault", 32'(f), 32'd1);

    do_req(1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, old, f);
    check(rdy[1] ? "ws_ready" : "ws_ready", 32'(rdy[1]), 32'd1);
    rv[1] = 1'b1; rwe[1] = 1'b1; rsz[1] = 2'b11; runs[1] = 1'b0;
    radr[1] = 32'h20; rwd[1] = ~old;
    @(posedge clk);
    #1 rv[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (vld[1]) seen++;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    check("abort_ready", 32'(rdy[1]), 32'd1);
    do_req(1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, rd, f);
    check("abort_old_data", rd, old);

    repeat (400) begin
      int          d;
      int          r;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 7));
      if (r == 0) a = $urandom_range(32'h400, 32'hFFFFFFFF);
      else        a = $urandom_range(0, 1023);
      if (r >= 1 && r <= 5) a = a & ~32'h3;
      do_req(d, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, rd, f);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
